enc_4_2_ser: RTL and testbench

- Sequential 4-to-2 priority encoder; the inverse of the team's 2-to-4 decoder.
- Captures a 4-bit request vector on a load strobe.
- Emits the 2-bit index of every set bit, lowest index first, one per accepted handshake. Index mapping is 0001->00, 0010->01, 0100->10, 1000->11.
- Sits between a one-hot or multi-hot request source and a downstream consumer of indices, such as a decoder-driven select.

---
 rtl/enc_4_2_ser.sv | 94 +++++++++
 tb/tb_enc_4_2_ser.sv | 130 +++++++++++++
 2 files changed

// File: rtl/enc_4_2_ser.sv
// Sequential 4-to-2 priority encoder: captures a request vector, then emits
// each set bit's index lowest-first under a vld/rdy handshake. ENC_COUNT_EN adds cnt.
module enc_4_2_ser (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] Din,
  output logic [1:0] Dout,
  output logic       vld,
  input  logic       rdy,
  output logic       busy,
  output logic       done,
`ifdef ENC_COUNT_EN
  output logic [2:0] cnt,
`endif
  output logic       none
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state_reg;
  logic [3:0] pend_reg;
  logic [3:0] rem;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Requests still pending once the index currently on Dout is accepted.
  assign rem = pend_reg & ~(4'b0001 << Dout);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pend_reg  <= 4'b0000;
      Dout      <= 2'b00;
      vld       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      none      <= 1'b0;
    end else begin
      done <= 1'b0;
      none <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ld) begin
            if (Din != 4'b0000) begin
              pend_reg  <= Din;
              Dout      <= lowest_idx(Din);
              vld       <= 1'b1;
              busy      <= 1'b1;
              state_reg <= EMIT;
            end else begin
              none <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (rdy) begin
            pend_reg <= rem;
            if (rem != 4'b0000) begin
              Dout <= lowest_idx(rem);
            end else begin
              vld       <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef ENC_COUNT_EN
  function automatic logic [2:0] popcount(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Latched on every accepted load, all-zero loads included.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'b000;
    end else if (state_reg == IDLE && ld) begin
      cnt <= popcount(Din);
    end
  end
`endif

endmodule

// File: tb/tb_enc_4_2_ser.sv
// Directed bench for enc_4_2_ser: per-cycle vector table plus hand-written
// reset sequences. Define ENC_COUNT_EN to also check cnt.
module tb_enc_4_2_ser;

  logic       clk = 1'b0;
  logic       rst, ld, rdy;
  logic [3:0] Din;
  logic [1:0] Dout;
  logic       vld, busy, done, none;
`ifdef ENC_COUNT_EN
  logic [2:0] cnt;
`endif

  enc_4_2_ser dut (
    .clk(clk), .rst(rst), .ld(ld), .Din(Din), .Dout(Dout), .vld(vld),
    .rdy(rdy), .busy(busy), .done(done),
`ifdef ENC_COUNT_EN
    .cnt(cnt),
`endif
    .none(none)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] din;
    logic       rdy;
    logic       chk_dout;
    logic [1:0] dout;
    logic       vld;
    logic       busy;
    logic       done;
    logic       none;
    logic [2:0] cnt;
  } vec_t;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[23];

  function automatic vec_t mk(input logic r, input logic l, input logic [3:0] d,
                              input logic y, input logic cd, input logic [1:0] o,
                              input logic v, input logic b, input logic dn,
                              input logic nn, input logic [2:0] c);
    vec_t t;
    t.rst = r; t.ld = l; t.din = d; t.rdy = y; t.chk_dout = cd; t.dout = o;
    t.vld = v; t.busy = b; t.done = dn; t.none = nn; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, check the registered outputs.
  task automatic apply(input vec_t t, input int idx);
    rst = t.rst; ld = t.ld; Din = t.din; rdy = t.rdy;
    @(posedge clk);
    #1;
    n_vec++;
    if (t.chk_dout) chk("dout", idx, int'(Dout), int'(t.dout));
    chk("vld",  idx, int'(vld),  int'(t.vld));
    chk("busy", idx, int'(busy), int'(t.busy));
    chk("done", idx, int'(done), int'(t.done));
    chk("none", idx, int'(none), int'(t.none));
`ifdef ENC_COUNT_EN
    chk("cnt",  idx, int'(cnt),  int'(t.cnt));
`endif
    $display("vec %0d rst=%b ld=%b Din=%b rdy=%b -> Dout=%b vld=%b busy=%b done=%b none=%b",
             idx, t.rst, t.ld, t.din, t.rdy, Dout, vld, busy, done, none);
  endtask

  initial begin
    //            rst ld  din      rdy cd dout   vld busy done none cnt
    tbl[0]  = mk(1, 0, 4'b0000, 0, 1, 2'd0, 0, 0, 0, 0, 3'd0);  // reset
    tbl[1]  = mk(0, 1, 4'b0100, 1, 1, 2'd2, 1, 1, 0, 0, 3'd1);  // single bit
    tbl[2]  = mk(0, 0, 4'b0000, 1, 0, 2'd0, 0, 0, 1, 0, 3'd1);
    tbl[3]  = mk(0, 1, 4'b1111, 1, 1, 2'd0, 1, 1, 0, 0, 3'd4);  // load in done cycle
    tbl[4]  = mk(0, 0, 4'b0000, 1, 1, 2'd1, 1, 1, 0, 0, 3'd4);
    tbl[5]  = mk(0, 0, 4'b0000, 1, 1, 2'd2, 1, 1, 0, 0, 3'd4);
    tbl[6]  = mk(0, 0, 4'b0000, 1, 1, 2'd3, 1, 1, 0, 0, 3'd4);
    tbl[7]  = mk(0, 0, 4'b0000, 1, 0, 2'd0, 0, 0, 1, 0, 3'd4);
    tbl[8]  = mk(0, 1, 4'b1010, 0, 1, 2'd1, 1, 1, 0, 0, 3'd2);  // backpressure
    tbl[9]  = mk(0, 0, 4'b0000, 0, 1, 2'd1, 1, 1, 0, 0, 3'd2);
    tbl[10] = mk(0, 0, 4'b0000, 0, 1, 2'd1, 1, 1, 0, 0, 3'd2);
    tbl[11] = mk(0, 0, 4'b0000, 0, 1, 2'd1, 1, 1, 0, 0, 3'd2);
    tbl[12] = mk(0, 0, 4'b0000, 1, 1, 2'd3, 1, 1, 0, 0, 3'd2);
    tbl[13] = mk(0, 0, 4'b0000, 1, 0, 2'd0, 0, 0, 1, 0, 3'd2);
    tbl[14] = mk(0, 1, 4'b0000, 1, 0, 2'd0, 0, 0, 0, 1, 3'd0);  // all-zero load
    tbl[15] = mk(0, 0, 4'b0000, 1, 0, 2'd0, 0, 0, 0, 0, 3'd0);
    tbl[16] = mk(0, 1, 4'b0110, 1, 1, 2'd1, 1, 1, 0, 0, 3'd2);
    tbl[17] = mk(0, 1, 4'b1000, 1, 1, 2'd2, 1, 1, 0, 0, 3'd2);  // ld ignored
    tbl[18] = mk(0, 1, 4'b1000, 1, 0, 2'd0, 0, 0, 1, 0, 3'd2);  // ld ignored
    tbl[19] = mk(0, 1, 4'b1000, 1, 1, 2'd3, 1, 1, 0, 0, 3'd1);  // accepted
    tbl[20] = mk(0, 0, 4'b0000, 0, 1, 2'd3, 1, 1, 0, 0, 3'd1);
    tbl[21] = mk(0, 0, 4'b0000, 1, 0, 2'd0, 0, 0, 1, 0, 3'd1);
    tbl[22] = mk(0, 0, 4'b0000, 1, 0, 2'd0, 0, 0, 0, 0, 3'd1);

    rst = 1'b1; ld = 1'b0; Din = 4'b0000; rdy = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) apply(tbl[i], i);

    // Reset mid-drain discards the rest and issues no done pulse.
    apply(mk(0, 1, 4'b1111, 1, 1, 2'd0, 1, 1, 0, 0, 3'd4), 100);
    apply(mk(0, 0, 4'b0000, 1, 1, 2'd1, 1, 1, 0, 0, 3'd4), 101);
    apply(mk(1, 0, 4'b0000, 1, 1, 2'd0, 0, 0, 0, 0, 3'd0), 102);
    apply(mk(0, 0, 4'b0000, 1, 1, 2'd0, 0, 0, 0, 0, 3'd0), 103);
    apply(mk(0, 1, 4'b0001, 1, 1, 2'd0, 1, 1, 0, 0, 3'd1), 104);
    apply(mk(0, 0, 4'b0000, 1, 0, 2'd0, 0, 0, 1, 0, 3'd1), 105);

    // Reset wins over a simultaneous load, and over a handshake mid-drain.
    apply(mk(1, 1, 4'b0011, 1, 1, 2'd0, 0, 0, 0, 0, 3'd0), 110);
    apply(mk(0, 1, 4'b1100, 0, 1, 2'd2, 1, 1, 0, 0, 3'd2), 111);
    apply(mk(1, 1, 4'b0001, 1, 1, 2'd0, 0, 0, 0, 0, 3'd0), 112);
    apply(mk(0, 0, 4'b0000, 1, 1, 2'd0, 0, 0, 0, 0, 3'd0), 113);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
